// File: rtl/display_pkg.sv
// Shared types and constants for the segment-display scheduler.
// A frame is four 5-bit digits ({dp, hex}); digit d sits at [5d+4:5d].
package display_pkg;

    localparam int DIGITS = 4;

    typedef logic [4:0]  digit_t;
    typedef logic [19:0] frame_t;

    typedef enum logic {IDLE, SHOW} state_t;

    // Bits needed for a counter that runs 0..n-1; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/display_rr_pick.sv
// Combinational round-robin picker.
// Searches i_req upward starting at i_ptr+1 (with wrap) and reports the
// first set bit. i_ptr itself is checked last, so the last winner has the
// lowest priority.
// Ports:
//   i_req  - request vector, one bit per requester
//   i_ptr  - index of the last granted requester
//   o_vld  - at least one request is set
//   o_idx  - index of the selected requester (valid when o_vld)
module display_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_vld  = 1'b0;
        o_idx  = '0;
        w_cand = '0;
        // Walk from farthest to nearest so the nearest set bit wins.
        for (int i = N; i >= 1; i--) begin
            w_cand = IDX_W'((int'(i_ptr) + i) % N);
            if (i_req[w_cand]) begin
                o_vld = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares the 4-digit segment display between NUM_REQ requesters.
// Requests are granted round-robin; a granted frame is held for
// HOLD_TICKS*TICK_DIV cycles, optionally blinking against IdleFrame.
// Ports:
//   Clk, Reset  - clock, synchronous active-high reset
//   ReqValid    - pending request per requester (sampled only in IDLE)
//   ReqFrame    - frame of requester n at [20n+19:20n]
//   ReqBlink    - blink flag per requester, captured with the frame
//   IdleFrame   - frame shown when no grant is active / blink off phase
//   ReqAck      - one-cycle pulse when a frame is captured
//   ReqDone     - one-cycle pulse when the hold time expires
//   Values      - registered digit values for the display multiplexer
//   Busy        - high while a frame is being shown
//   GrantId     - current or last granted requester
module display_scheduler
    import display_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TICK_DIV    = 50000,
    parameter int HOLD_TICKS  = 1000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_REQ-1:0]         ReqValid,
    input  logic [20*NUM_REQ-1:0]      ReqFrame,
    input  logic [NUM_REQ-1:0]         ReqBlink,
    input  logic [19:0]                IdleFrame,
    output logic [NUM_REQ-1:0]         ReqAck,
    output logic [NUM_REQ-1:0]         ReqDone,
    output logic [4:0]                 Values [0:DIGITS-1],
    output logic                       Busy,
    output logic [$clog2(NUM_REQ)-1:0] GrantId
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int DIV_W = cnt_w(TICK_DIV);
    localparam int HLD_W = cnt_w(HOLD_TICKS);
    localparam int BLK_W = cnt_w(BLINK_TICKS);

    state_t           r_state, w_nxt_state;
    logic [DIV_W-1:0] r_div,   w_nxt_div;
    logic [HLD_W-1:0] r_hold,  w_nxt_hold;
    logic [BLK_W-1:0] r_bcnt,  w_nxt_bcnt;
    logic             r_phase, w_nxt_phase;  // 1 = blink on phase
    logic             r_blink, w_nxt_blink;
    frame_t           r_frame, w_nxt_frame;
    logic [IDX_W-1:0] r_grant, w_nxt_grant;
    logic [IDX_W-1:0] r_ptr,   w_nxt_ptr;
    logic [NUM_REQ-1:0] w_ack, w_done;
    logic             w_tick, w_last;
    frame_t           w_val;

    logic             w_pick_vld;
    logic [IDX_W-1:0] w_pick_idx;

    display_rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req (ReqValid),
        .i_ptr (r_ptr),
        .o_vld (w_pick_vld),
        .o_idx (w_pick_idx)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_div   = r_div;
        w_nxt_hold  = r_hold;
        w_nxt_bcnt  = r_bcnt;
        w_nxt_phase = r_phase;
        w_nxt_blink = r_blink;
        w_nxt_frame = r_frame;
        w_nxt_grant = r_grant;
        w_nxt_ptr   = r_ptr;
        w_ack       = '0;
        w_done      = '0;
        w_tick      = (r_div == DIV_W'(TICK_DIV - 1));
        w_last      = w_tick && (r_hold == HLD_W'(HOLD_TICKS - 1));

        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_nxt_state        = SHOW;
                    w_nxt_div          = '0;
                    w_nxt_hold         = '0;
                    w_nxt_bcnt         = '0;
                    w_nxt_phase        = 1'b1;
                    w_nxt_frame        = ReqFrame[20*w_pick_idx +: 20];
                    w_nxt_blink        = ReqBlink[w_pick_idx];
                    w_nxt_grant        = w_pick_idx;
                    w_nxt_ptr          = w_pick_idx;
                    w_ack[w_pick_idx]  = 1'b1;
                end
            end
            SHOW: begin
                if (w_last) begin
                    w_nxt_state     = IDLE;
                    w_done[r_grant] = 1'b1;
                end else if (w_tick) begin
                    w_nxt_div  = '0;
                    w_nxt_hold = r_hold + 1'b1;
                    if (r_bcnt == BLK_W'(BLINK_TICKS - 1)) begin
                        w_nxt_bcnt  = '0;
                        w_nxt_phase = ~r_phase;
                    end else begin
                        w_nxt_bcnt = r_bcnt + 1'b1;
                    end
                end else begin
                    w_nxt_div = r_div + 1'b1;
                end
            end
            default: w_nxt_state = IDLE;
        endcase

        // Values is registered, so it is derived from the next state.
        if (w_nxt_state == IDLE || (w_nxt_blink && !w_nxt_phase))
            w_val = IdleFrame;
        else
            w_val = w_nxt_frame;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_hold  <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b0;
            r_blink <= 1'b0;
            r_frame <= '0;
            r_grant <= '0;
            r_ptr   <= IDX_W'(NUM_REQ - 1);
            ReqAck  <= '0;
            ReqDone <= '0;
            for (int d = 0; d < DIGITS; d++) Values[d] <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_div   <= w_nxt_div;
            r_hold  <= w_nxt_hold;
            r_bcnt  <= w_nxt_bcnt;
            r_phase <= w_nxt_phase;
            r_blink <= w_nxt_blink;
            r_frame <= w_nxt_frame;
            r_grant <= w_nxt_grant;
            r_ptr   <= w_nxt_ptr;
            ReqAck  <= w_ack;
            ReqDone <= w_done;
            for (int d = 0; d < DIGITS; d++) Values[d] <= w_val[5*d +: 5];
        end
    end

    assign Busy    = (r_state == SHOW);
    assign GrantId = r_grant;

endmodule

// File: tb/tb_display_scheduler.sv
module tb_display_scheduler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  ReqValid;
    logic [79:0] ReqFrame;
    logic [3:0]  ReqBlink;
    logic [19:0] IdleFrame;
    logic [3:0]  ReqAck;
    logic [3:0]  ReqDone;
    logic [4:0]  Values [0:3];
    logic        Busy;
    logic [1:0]  GrantId;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [19:0] f [0:3];

    display_scheduler #(
        .NUM_REQ(4), .TICK_DIV(4), .HOLD_TICKS(3), .BLINK_TICKS(1)
    ) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqFrame(ReqFrame),
        .ReqBlink(ReqBlink), .IdleFrame(IdleFrame), .ReqAck(ReqAck),
        .ReqDone(ReqDone), .Values(Values), .Busy(Busy), .GrantId(GrantId)
    );

    always #5 Clk = ~Clk;

    function automatic logic [19:0] vals();
        return {Values[3], Values[2], Values[1], Values[0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] ack, input logic [3:0] done,
                       input logic busy, input logic [19:0] v);
        chk({tag, ".ack"},  32'(ReqAck),  32'(ack));
        chk({tag, ".done"}, 32'(ReqDone), 32'(done));
        chk({tag, ".busy"}, 32'(Busy),    32'(busy));
        chk({tag, ".val"},  32'(vals()),  32'(v));
    endtask

    // Bounded wait for the next nonzero pulse on ReqAck (sel=0) or ReqDone (sel=1).
    task automatic wait_pulse(input bit sel, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if ((sel ? ReqDone : ReqAck) != 4'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic set_frames();
        ReqFrame = {f[3], f[2], f[1], f[0]};
    endtask

    initial begin
        int n;
        f[0] = 20'h11111; f[1] = 20'h08421; f[2] = 20'h33333; f[3] = 20'h44444;
        Reset = 1'b1; ReqValid = '0; ReqBlink = '0; IdleFrame = 20'h0A5A5;
        set_frames();

        // Reset state
        repeat (3) begin
            @(negedge Clk);
            cyc("rst", 4'b0, 4'b0, 1'b0, 20'h0);
        end
        chk("rst.gid", 32'(GrantId), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        cyc("rel", 4'b0, 4'b0, 1'b0, 20'h0A5A5);

        // Single request from requester 1
        ReqValid = 4'b0010;
        for (int k = 1; k <= 13; k++) begin
            @(negedge Clk);
            if (k == 1)        cyc($sformatf("single.k%0d", k), 4'b0010, 4'b0, 1'b1, 20'h08421);
            else if (k <= 12)  cyc($sformatf("single.k%0d", k), 4'b0, 4'b0, 1'b1, 20'h08421);
            else               cyc($sformatf("single.k%0d", k), 4'b0, 4'b0010, 1'b0, 20'h0A5A5);
            if (k == 1) ReqValid = 4'b0;
        end
        chk("single.gid", 32'(GrantId), 32'd1);

        // Fairness: all requesters held high from reset
        Reset = 1'b1; ReqValid = 4'b1111;
        @(negedge Clk);
        Reset = 1'b0;
        for (int r = 0; r < 5; r++) begin
            wait_pulse(1'b0, n);
            chk($sformatf("fair%0d.gap", r), 32'(n), (r == 0) ? 32'd1 : 32'd13);
            chk($sformatf("fair%0d.ack", r), 32'(ReqAck), 32'(4'b0001 << (r % 4)));
            chk($sformatf("fair%0d.val", r), 32'(vals()), 32'(f[r % 4]));
            chk($sformatf("fair%0d.done", r), 32'(ReqDone), 32'd0);
        end
        ReqValid = 4'b0;
        wait_pulse(1'b1, n);
        chk("fair.donegap", 32'(n), 32'd12);
        cyc("fair.end", 4'b0, 4'b0001, 1'b0, 20'h0A5A5);

        // Blink on requester 0
        f[0] = 20'h12345; set_frames();
        ReqValid = 4'b0001; ReqBlink = 4'b0001;
        for (int k = 1; k <= 13; k++) begin
            @(negedge Clk);
            if (k == 1) ReqValid = 4'b0;
            if (k >= 5 && k <= 8)
                chk($sformatf("blink.k%0d", k), 32'(vals()), 32'h0A5A5);
            else if (k <= 12)
                chk($sformatf("blink.k%0d", k), 32'(vals()), 32'h12345);
            else
                cyc("blink.end", 4'b0, 4'b0001, 1'b0, 20'h0A5A5);
        end
        ReqBlink = 4'b0;

        // IdleFrame change seen one cycle later while idle
        IdleFrame = 20'h0BEEF;
        @(negedge Clk);
        chk("idlechg", 32'(vals()), 32'h0BEEF);

        // Withdraw: requester 2 appears during SHOW and drops before Done
        ReqValid = 4'b0001;
        for (int k = 1; k <= 15; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                chk("wd.ack0", 32'(ReqAck), 32'b0001);
                ReqValid = 4'b0;
            end else begin
                chk($sformatf("wd.k%0d.ack", k), 32'(ReqAck), 32'd0);
            end
            if (k == 3) ReqValid = 4'b0100;
            if (k == 8) ReqValid = 4'b0;
            if (k == 13) chk("wd.done", 32'(ReqDone), 32'b0001);
        end
        chk("wd.busy", 32'(Busy), 32'd0);

        // Reset mid-SHOW of requester 1; pointer must return to reset value
        ReqValid = 4'b0010;
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            if (k == 1) begin
                chk("rms.ack1", 32'(ReqAck), 32'b0010);
                ReqValid = 4'b0;
            end
        end
        Reset = 1'b1; ReqValid = 4'b1001;
        @(negedge Clk);
        cyc("rms.rst", 4'b0, 4'b0, 1'b0, 20'h0);
        chk("rms.gid", 32'(GrantId), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        cyc("rms.g0", 4'b0001, 4'b0, 1'b1, 20'h12345);
        ReqValid = 4'b1000;
        wait_pulse(1'b0, n);
        chk("rms.gap3", 32'(n), 32'd13);
        chk("rms.ack3", 32'(ReqAck), 32'b1000);
        chk("rms.val3", 32'(vals()), 32'h44444);
        ReqValid = 4'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the 4-digit segment display between up to NUM_REQ requesters (game status, score, messages). Each request carries a complete 4-digit frame. The block grants requesters in round-robin order and holds each granted frame for a fixed number of ticks, with optional blink. Its registered Values output drives the SegmentDisplay multiplexer directly; an idle frame is shown when no grant is active.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TICK_DIV, 50000, Clk cycles per tick (≥1)
- HOLD_TICKS, 1000, ticks a granted frame is held (≥1)
- BLINK_TICKS, 250, ticks per blink half-period (≥1)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- ReqValid  in  NUM_REQ  request pending, one bit per requester
- ReqFrame  in  20*NUM_REQ  frame of requester n at [20n+19:20n]; digit d at [5d+4:5d] ({dp, hex})
- ReqBlink  in  NUM_REQ  blink flag, captured with the frame
- IdleFrame  in  20  frame shown when no grant is active
- ReqAck  out  NUM_REQ  one-cycle pulse: frame captured
- ReqDone  out  NUM_REQ  one-cycle pulse: hold expired
- Values  out  5 x [0:3]  digit values to SegmentDisplay; registered
- Busy  out  1  high in SHOW
- GrantId  out  $clog2(NUM_REQ)  current or last granted requester

## Operation
- States: IDLE, SHOW. Reset state is IDLE.
- **IDLE:** if any ReqValid bit is set, the picker selects the first set bit searching upward from rr_ptr+1, with wrap.
  - At the clock edge: capture the selected frame and blink flag; set GrantId and rr_ptr to the selected index; pulse ReqAck of the selected index; go to SHOW.
- **SHOW:**
  - ReqValid is ignored; the captured frame is frozen.
  - The tick prescaler and the hold and blink counters restart at the grant.
  - After exactly HOLD_TICKS*TICK_DIV cycles in SHOW: pulse ReqDone of GrantId and return to IDLE.
- **Handshake:**
  - A requester holds ReqValid until it sees its ReqAck.
  - Dropping ReqValid before ReqAck withdraws the request without error.
  - Holding ReqValid high after ReqDone re-requests; the requester is served again only after the other pending requesters.
- **Values** is registered and computed from the next state:
  - Next state IDLE: IdleFrame.
  - Next state SHOW with blink clear: the captured frame.
  - Next state SHOW with blink set: the captured frame in the on phase, IdleFrame in the off phase.
  - The blink phase starts on and toggles every BLINK_TICKS ticks.
- **Reset values:**
  - Values all 5'd0; ReqAck 0; ReqDone 0; Busy 0; GrantId 0.
  - rr_ptr = NUM_REQ-1, so requester 0 wins first.
  - All counters 0.
- **Reset mid-SHOW:** abort immediately. No ReqDone is issued, and the round-robin pointer returns to its reset value.
- Counter widths are sized from the parameters, with no truncation at maximum values.

## Timing
- Request visible in IDLE at cycle t produces ReqAck and Values = frame in cycle t+1.
- SHOW occupies cycles t+1 .. t+H, where H = HOLD_TICKS*TICK_DIV.
- ReqDone, state IDLE and Values = IdleFrame all occur in cycle t+H+1.
- That IDLE cycle may grant again, so the next ReqAck can come at t+H+2. Grant period under full load is H+1 cycles.
- IdleFrame changes reach Values one cycle later while in IDLE.
- ReqAck and ReqDone never pulse for more than one cycle. They are never both high in the same cycle.

## Structure
- **Package display_pkg:**
  - `digit_t` (logic [4:0]) and `frame_t` (logic [19:0])
  - state enum `{IDLE, SHOW}`
  - DIGITS = 4
- **Sub-module display_rr_pick:** combinational round-robin picker. Inputs: request vector and pointer. Outputs: grant-valid and index. It can be reused by other shared-resource controllers.

## Test plan
Parameters for all scenarios: TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=1, NUM_REQ=4, so H=12.
- **Reset:** hold Reset with IdleFrame=0x0A5A5 -> Values all 0, Busy 0, no pulses; one cycle after release -> Values = IdleFrame.
- **Single request:** ReqValid[1] with frame 0x08421 at cycle t -> ReqAck[1] at t+1; Values=0x08421 for t+1..t+12; ReqDone[1] and IdleFrame at t+13; Busy high t+1..t+12.
- **Fairness:** all four ReqValid held high from reset -> ReqAck order 0,1,2,3,0 at cycles 2,15,28,41,54.
- **Blink:** ReqBlink[0]=1 -> frame for t+1..t+4, IdleFrame for t+5..t+8, frame for t+9..t+12.
- **Withdraw:** ReqValid[2] asserted during SHOW of requester 0, dropped before Done -> no ReqAck[2]; block returns to IDLE.
- **Reset mid-SHOW:** Reset at t+5 -> no ReqDone; Values 0 next cycle; after release a pending request 0 is granted before request 3.
